// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the default
// bit period used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 10417;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; both flops reset
// to RST_VAL so the output starts at the input's idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples mid-bit off a synchronized line, emits each good
// byte with a one-cycle strobe and flags a low stop bit as a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic rxs;

  uart_state_t               state_q, state_n;
  logic [CNT_W-1:0]          cnt_q,   cnt_n;
  logic [IDX_W-1:0]          idx_q,   idx_n;
  logic [UART_DATA_BITS-1:0] shift_q, shift_n;
  logic [UART_DATA_BITS-1:0] data_q,  data_n;
  logic                      valid_q, valid_n;
  logic                      err_q,   err_n;
  logic                      busy_q,  busy_n;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
    end
  end

  // Next-state, bit timing, shifting and output strobes.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shift_n = shift_q;
    data_n  = data_q;
    valid_n = 1'b0;
    err_n   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) begin
          state_n = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = IDLE;
          end else begin
            idx_n   = '0;
            state_n = DATA;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rxs, shift_q[UART_DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_n = STOP;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      STOP: begin
        // Leave at mid-stop so a following start edge is never missed.
        if (cnt_q == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rxs) begin
            data_n  = shift_q;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clk/bit: directed frame table, glitch and reset
// sequences, and random traffic checked against a line-sampling model.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned at_edge;
    bit          err;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         c2;
    int         gap;
    int         kind;
    logic [7:0] exp_data;
  } row_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   log_en  = 1'b0;
  bit   line_log[$];
  ev_t  ev_q[$];
  ev_t  exp_q[$];
  ev_t  mon_e;
  logic pulse_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Line level seen by each active edge, indexed from the last reset release.
  always @(posedge clk) begin
    if (log_en) line_log.push_back(rx);
  end

  always @(negedge clk) begin
    if (log_en && (rx_valid || frame_err)) begin
      mon_e.at_edge = line_log.size() - 1;
      mon_e.err     = frame_err;
      mon_e.data    = rx_data;
      ev_q.push_back(mon_e);
      chk("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
      chk("busy_during_pulse", 32'(busy), 32'd0);
      chk("pulse_one_cycle", 32'(pulse_d), 32'd0);
    end
    pulse_d = rx_valid | frame_err;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // c2 is twice the clk/bit, so bit edges may fall on half-cycle averages.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int c2,
                            output int unsigned t0);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    t0   = line_log.size();
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      repeat (((b + 1) * c2) / 2 - (b * c2) / 2) @(negedge clk);
    end
  endtask

  function automatic bit see(input int t);
    if (t < 2 || t - 2 >= line_log.size()) return 1'b1;
    return line_log[t-2];
  endfunction

  // Receiver as a list of sampling instants: each frame's samples sit at
  // E + C/2 + k*C after the first low seen, and the pulse lands on the stop sample.
  task automatic run_model();
    int         t;
    int         mid;
    int         s;
    int         n;
    logic [7:0] b;
    logic [7:0] last;
    ev_t        e;
    exp_q.delete();
    last = 8'h00;
    n    = line_log.size();
    t    = 0;
    while (t + 2 < n) begin
      if (see(t)) begin
        t++;
      end else begin
        mid = t + H;
        if (see(mid)) begin
          t = mid + 1;
        end else begin
          s = mid + 9 * C;
          if (s + 2 >= n) break;
          for (int k = 0; k < 8; k++) b[k] = see(mid + (k + 1) * C);
          e.at_edge = s;
          if (see(s)) begin
            last  = b;
            e.err = 1'b0;
          end else begin
            e.err = 1'b1;
          end
          e.data = last;
          exp_q.push_back(e);
          t = s + 1;
        end
      end
    end
  endtask

  task automatic reset_and_clear();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    line_log.delete();
    ev_q.delete();
  endtask

  row_t        tbl[7];
  int unsigned t0s[7];

  initial begin
    int          busy_cnt;
    int unsigned tdummy;
    int          m;

    tbl[0] = '{8'hA5, 1'b1, 32, 20, 1, 8'hA5};
    tbl[1] = '{8'h00, 1'b1, 32, 0,  1, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 32, 20, 1, 8'hFF};
    tbl[3] = '{8'h3C, 1'b0, 32, 20, 2, 8'hFF};
    tbl[4] = '{8'h5A, 1'b1, 31, 20, 1, 8'h5A};
    tbl[5] = '{8'h5A, 1'b1, 33, 20, 1, 8'h5A};
    tbl[6] = '{8'hC3, 1'b1, 32, 20, 1, 8'hC3};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n  = 1'b1;
    log_en = 1'b1;
    line_log.delete();
    ev_q.delete();
    idle(5);

    // Directed frames, then compare every pulse against its row.
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].c2, t0s[i]);
      idle(tbl[i].gap);
    end
    chk("tbl_event_count", 32'(ev_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < ev_q.size(); i++) begin
      chk($sformatf("tbl%0d_edge", i), ev_q[i].at_edge, t0s[i] + 154);
      chk($sformatf("tbl%0d_err", i), 32'(ev_q[i].err), 32'(tbl[i].kind == 2));
      chk($sformatf("tbl%0d_data", i), 32'(ev_q[i].data), 32'(tbl[i].exp_data));
    end
    if (ev_q.size() >= 3)
      chk("back_to_back_spacing", ev_q[2].at_edge - ev_q[1].at_edge, 32'd160);
    chk("busy_after_table", 32'(busy), 32'd0);

    // Short low glitch is rejected at mid-start.
    ev_q.delete();
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("glitch_no_pulse", 32'(ev_q.size()), 32'd0);

    // Reset mid-frame after data bit 3 of 0x81, then a clean 0x42.
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      m  = 32'h81 >> b;
      rx = m[0];
      repeat (C) @(negedge clk);
    end
    chk("busy_mid_frame", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rx_data", 32'(rx_data), 32'h00);
    chk("async_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("async_rst_frame_err", 32'(frame_err), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    ev_q.delete();
    idle(10);
    send_frame(8'h42, 1'b1, 32, tdummy);
    idle(30);
    chk("post_rst_event_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() > 0) begin
      chk("post_rst_err", 32'(ev_q[0].err), 32'd0);
      chk("post_rst_data", 32'(ev_q[0].data), 32'h42);
    end

    // Random traffic: 15..17 clk/bit in half steps, occasional bad stop bits.
    reset_and_clear();
    for (int i = 0; i < 30; i++) begin
      send_frame(8'($urandom), ($urandom_range(7, 0) != 0), 30 + int'($urandom_range(4, 0)),
                 tdummy);
      idle(int'($urandom_range(12, 0)));
    end
    idle(200);
    run_model();
    chk("rand_event_count", 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("rand%0d_edge", i), ev_q[i].at_edge, exp_q[i].at_edge);
      chk($sformatf("rand%0d_err", i), 32'(ev_q[i].err), 32'(exp_q[i].err));
      chk($sformatf("rand%0d_data", i), 32'(ev_q[i].data), 32'(exp_q[i].data));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
